// File: rtl/alu_mul_frontend.sv
// RV32M multiply issue/retire wrapper around the unsigned alu_mul core: operand magnitude
// conversion, sign/op sideband pipe, product sign fix-up and an in-order output FIFO.
module alu_mul_frontend #(
   parameter int MUL_LAT   = 6,
   parameter int OUT_DEPTH = 8,
   parameter int TAG_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      mul_a,
   output logic [31:0]      mul_b,
   input  logic [63:0]      mul_dest,
   input  logic             mul_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             dbg_state
);
   // Handshake: a request transfers on a rising edge where in_valid & in_ready; a result
   // leaves on a rising edge where out_valid & out_ready. Neither valid waits on its ready.
   localparam int SB_N = MUL_LAT + 1;
   localparam int PW   = $clog2(OUT_DEPTH);
   localparam int CW   = $clog2(OUT_DEPTH + SB_N + 1);
   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [PW:0] CNT_ONE  = {{PW{1'b0}}, 1'b1};

   typedef enum logic {WAIT_CORE = 1'b0, RUN = 1'b1} state_t;
   state_t state_q;

   logic [31:0]                mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [SB_N-1:0]            sb_valid_q, sb_valid_d, sb_neg_q, sb_neg_d;
   logic [SB_N-1:0][1:0]       sb_op_q, sb_op_d;
   logic [SB_N-1:0][TAG_W-1:0] sb_tag_q, sb_tag_d;
   logic [OUT_DEPTH-1:0][TAG_W+31:0] mem_q, mem_d;
   logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]                count_q, count_d;

   logic [CW-1:0] inflight, credits_used;
   logic          accept, push, pop, signed_a, signed_b, neg_a, neg_b;
   logic [63:0]   fixed_prod;
   logic [31:0]   push_data;

   // Every op in flight already owns a FIFO slot, so a push can never be refused.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < SB_N; i++) inflight = inflight + CW'(sb_valid_q[i]);
      credits_used = inflight + CW'(count_q);
   end

   assign in_ready = mul_ready & ~flush & ~rst & (credits_used < CW'(OUT_DEPTH));
   assign accept   = in_valid & in_ready;

   assign signed_a = (in_op == OP_MULH) | (in_op == OP_MULHSU);
   assign signed_b = (in_op == OP_MULH);
   assign neg_a    = signed_a & in_a[31];
   assign neg_b    = signed_b & in_b[31];

   // The oldest sideband stage lines up with the core product for the same op.
   assign push       = sb_valid_q[SB_N-1];
   assign fixed_prod = sb_neg_q[SB_N-1] ? (~mul_dest + 64'd1) : mul_dest;
   assign push_data  = (sb_op_q[SB_N-1] == OP_MUL) ? fixed_prod[31:0] : fixed_prod[63:32];
   assign out_valid  = (count_q != '0);
   assign pop        = out_valid & out_ready;

   always_comb begin
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      if (accept) begin
         mul_a_d = neg_a ? (~in_a + 32'd1) : in_a;
         mul_b_d = neg_b ? (~in_b + 32'd1) : in_b;
      end
      sb_valid_d = {sb_valid_q[SB_N-2:0], accept};
      sb_neg_d   = {sb_neg_q[SB_N-2:0], neg_a ^ neg_b};
      sb_op_d    = {sb_op_q[SB_N-2:0], in_op};
      sb_tag_d   = {sb_tag_q[SB_N-2:0], in_tag};

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {sb_tag_q[SB_N-1], push_data};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // Products still inside the core are dropped simply by invalidating their sideband.
      if (flush) begin
         sb_valid_d = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         sb_valid_q <= '0;
         sb_neg_q   <= '0;
         sb_op_q    <= '0;
         sb_tag_q   <= '0;
         mem_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         sb_valid_q <= sb_valid_d;
         sb_neg_q   <= sb_neg_d;
         sb_op_q    <= sb_op_d;
         sb_tag_q   <= sb_tag_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Warm-up tracker: leaves WAIT_CORE once the core reports ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WAIT_CORE;
      end else begin
         case (state_q)
            WAIT_CORE: if (mul_ready) state_q <= RUN;
            default:   state_q <= RUN;
         endcase
      end
   end

   assign mul_a               = mul_a_q;
   assign mul_b               = mul_b_q;
   assign {out_tag, out_data} = mem_q[rd_ptr_q];
   assign dbg_state           = logic'(state_q);
endmodule

// File: tb/tb_alu_mul_frontend.sv
// Bench for alu_mul_frontend: behavioural alu_mul stand-in, directed RV32M corner cases,
// back-pressure, flush and reset scenarios, then a randomized soak against a reference model.
module tb_alu_mul_frontend;
   localparam int TAG_W = 5;
   localparam int W     = TAG_W + 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       in_op = 2'b00;
   logic [31:0]      in_a = '0;
   logic [31:0]      in_b = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic [31:0]      mul_a, mul_b;
   logic [63:0]      mul_dest;
   logic             mul_ready = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;
   logic             dbg_state;

   int n_vec = 0;
   int n_fail = 0;
   int n_pop = 0;
   int cyc = 0;
   logic [W-1:0] exp_q[$];

   alu_mul_frontend #(.MUL_LAT(6), .OUT_DEPTH(8), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .mul_a(mul_a), .mul_b(mul_b), .mul_dest(mul_dest), .mul_ready(mul_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / cycle count / watchdog ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- alu_mul stand-in: product visible 6 edges after sampling ----------------
   logic [63:0] core_pipe [6];
   always @(posedge clk) begin
      core_pipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
      for (int i = 1; i < 6; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign mul_dest = core_pipe[5];

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (op)
         2'b00:   p = ua * ub;
         2'b01:   p = sa * sb;
         2'b10:   p = sa * ub;
         default: p = ua * ub;
      endcase
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] ref_mag(input logic [31:0] v, input logic is_signed);
      longint s;
      s = longint'($signed(v));
      if (is_signed && s < 0) return 32'(-s);
      return v;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0001;
         default: return $urandom();
      endcase
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (rst || flush) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL sb_unexpected: observed tag %0h data %h, expected no result", out_tag, out_data);
            end
            if (exp_q.size() != 0) begin
               logic [W-1:0] exp_v;
               exp_v = exp_q.pop_front();
               n_vec++;
               n_pop++;
               assert ({out_tag, out_data} === exp_v) else begin
                  n_fail++;
                  $error("FAIL sb_result: observed %h, expected %h", {out_tag, out_data}, exp_v);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back({in_tag, ref_result(in_op, in_a, in_b)});
      end
   end

   // ---------------- driver / check tasks ----------------
   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", name, obs, exp_v);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, output int acc_edge);
      int waited;
      waited = 0;
      in_valid = 1'b1;
      in_op = op;
      in_a = a;
      in_b = b;
      in_tag = tag;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      chk("issue_accept", in_ready, 1);
      @(posedge clk);
      #1;
      acc_edge = cyc;
      in_valid = 1'b0;
   endtask

   task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_data);
      int acc_edge, waited;
      issue(op, a, b, TAG_W'($urandom_range(0, 31)), acc_edge);
      chk({name, "_mul_a"}, mul_a, ref_mag(a, (op == 2'b01) || (op == 2'b10)));
      chk({name, "_mul_b"}, mul_b, ref_mag(b, op == 2'b01));
      waited = 0;
      @(negedge clk);
      while (!out_valid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk({name, "_latency"}, 64'(cyc - acc_edge), 7);
      chk({name, "_data"}, out_data, exp_data);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int waited;
      waited = 0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      repeat (10) @(negedge clk);
      chk(name, 64'(exp_q.size()), 0);
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed steps ----------------
   initial begin
      int acc_edge, first_edge, n_acc, cons, stale, cnt, pops0, waited;

      // reset with core still warming up
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (in_ready) cnt++;
      end
      chk("warmup_no_ready", 64'(cnt), 0);
      chk("warmup_state", dbg_state, 0);
      @(posedge clk);
      #1;
      mul_ready = 1'b1;
      @(negedge clk);
      chk("warm_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      chk("run_state", dbg_state, 1);

      // RV32M corner cases
      directed("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      directed("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      directed("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      directed("mulh_m1", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);
      directed("mulhsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      directed("mul_fe3", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA);

      // 8 back-to-back ops, tags 0..7
      first_edge = 0;
      for (int i = 0; i < 8; i++) begin
         issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), TAG_W'(i), acc_edge);
         if (i == 0) first_edge = acc_edge;
      end
      waited = 0;
      @(negedge clk);
      while (!out_valid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk("b2b_first_latency", 64'(cyc - first_edge), 7);
      cons = 0;
      while (out_valid && cons < 20) begin
         cons++;
         @(negedge clk);
      end
      chk("b2b_consecutive", 64'(cons), 8);
      chk("b2b_sb_empty", 64'(exp_q.size()), 0);
      @(posedge clk);
      #1;

      // back-pressure: credits stop accepts at 8
      out_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 30; i++) begin
         in_valid = 1'b1;
         in_op = 2'($urandom_range(0, 3));
         in_a = pick_operand();
         in_b = pick_operand();
         in_tag = TAG_W'(i);
         @(negedge clk);
         if (in_ready) n_acc++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("bp_accepts", 64'(n_acc), 8);
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      @(posedge clk);
      #1;
      pops0 = n_pop;
      drain("bp_drained");
      chk("bp_result_count", 64'(n_pop - pops0), 8);

      // flush with 2 queued and 3 in flight
      out_ready = 1'b0;
      issue(2'b00, $urandom(), $urandom(), 5'd1, acc_edge);
      issue(2'b01, $urandom(), $urandom(), 5'd2, acc_edge);
      repeat (9) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) issue(2'b11, $urandom(), $urandom(), TAG_W'(10 + i), acc_edge);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_no_accept", in_ready, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
      out_ready = 1'b1;
      stale = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("flush_no_stale", 64'(stale), 0);
      @(posedge clk);
      #1;
      directed("post_flush_mul", 2'b00, 32'd3, 32'd5, 32'd15);

      // reset mid-stream
      for (int i = 0; i < 4; i++) issue(2'($urandom_range(0, 3)), $urandom(), $urandom(), TAG_W'(20 + i), acc_edge);
      rst = 1'b1;
      mul_ready = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midrst_mul_a", mul_a, 0);
      chk("midrst_mul_b", mul_b, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_out_tag", out_tag, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (in_ready || out_valid) cnt++;
      end
      chk("midrst_wait_core", 64'(cnt), 0);
      chk("midrst_state", dbg_state, 0);
      @(posedge clk);
      #1;
      mul_ready = 1'b1;
      directed("post_rst_mulh", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);

      // randomized soak with random issue gaps and writeback stalls
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_op = 2'($urandom_range(0, 3));
         in_a = pick_operand();
         in_b = pick_operand();
         in_tag = TAG_W'($urandom_range(0, 31));
         out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
      end
      drain("soak_drained");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
